// File: rtl/ptos_cycle_sequencer_pkg.sv
// Shared types and constants for the points-per-cycle sequencer.
package ptos_cycle_sequencer_pkg;
    localparam int N_WIDTH_DEF    = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int CYC_WIDTH_DEF  = 32;
    localparam int N_MIN          = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/ptos_cycle_sequencer_idx.sv
// Wrapping point-index counter holding the active cycle length n_active.
// o_wrap pulses combinationally on the step that takes idx from n_active-1 back to 0.
module ptos_idx_counter
    import ptos_cycle_sequencer_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_step,
    input  logic               i_load,
    input  logic [N_WIDTH-1:0] i_n,
    output logic [N_WIDTH-1:0] o_idx,
    output logic               o_last,
    output logic               o_wrap
);
    logic [N_WIDTH-1:0] r_idx;
    logic [N_WIDTH-1:0] r_n;

    assign o_idx  = r_idx;
    assign o_last = (r_idx == r_n - N_WIDTH'(1));
    assign o_wrap = i_step & o_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_n   <= '0;
        end else begin
            if (i_load) r_n <= i_n;
            if (i_clr)
                r_idx <= '0;
            else if (i_step)
                r_idx <= o_wrap ? '0 : r_idx + N_WIDTH'(1);
        end
    end
endmodule

// File: rtl/ptos_cycle_sequencer.sv
// Tags ADC samples with a point index and first/last flags, counts cycles, stops at a target.
// One-cycle latency from accepted sample to out_valid; samples outside RUN are dropped.
module ptos_cycle_sequencer
    import ptos_cycle_sequencer_pkg::*;
#(
    parameter int N_WIDTH    = N_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CYC_WIDTH  = CYC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_WIDTH-1:0]    ptos_x_ciclo,
    input  logic [CYC_WIDTH-1:0]  num_cycles,
    input  logic                  enable,
    input  logic                  sync_in,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [N_WIDTH-1:0]    out_idx,
    output logic                  out_first,
    output logic                  out_last,
    output logic [CYC_WIDTH-1:0]  cycle_count,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_error
);
    state_t               r_state;
    logic                 r_sync_d;
    logic [CYC_WIDTH-1:0] r_tgt;

    logic                 w_sync_edge;
    logic                 w_cfg_ok;
    logic                 w_arm_ok;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_wrap;
    logic                 w_last;
    logic [N_WIDTH-1:0]   w_idx;
    logic [CYC_WIDTH-1:0] w_cc_inc;

    assign w_sync_edge = sync_in & ~r_sync_d;
    assign w_cfg_ok    = (ptos_x_ciclo >= N_WIDTH'(N_MIN));
    assign w_arm_ok    = (r_state == ST_IDLE) & enable & w_cfg_ok;
    assign w_abort     = ((r_state == ST_ARM) | (r_state == ST_RUN)) & ~enable;
    // The sample coincident with the aligning sync edge is already point 0.
    assign w_accept    = enable & in_valid &
                         ((r_state == ST_RUN) | ((r_state == ST_ARM) & w_sync_edge));
    assign w_cc_inc    = cycle_count + CYC_WIDTH'(1);
    assign busy        = (r_state == ST_ARM) | (r_state == ST_RUN);

    ptos_idx_counter #(.N_WIDTH(N_WIDTH)) u_idx (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_arm_ok | w_abort),
        .i_step (w_accept),
        .i_load (w_arm_ok | (w_wrap & w_cfg_ok)),
        .i_n    (ptos_x_ciclo),
        .o_idx  (w_idx),
        .o_last (w_last),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sync_d    <= 1'b0;
            r_tgt       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            cycle_count <= '0;
            done        <= 1'b0;
            cfg_error   <= 1'b0;
        end else begin
            r_sync_d  <= sync_in;
            out_valid <= w_accept;
            if (w_accept) begin
                out_data  <= in_data;
                out_idx   <= w_idx;
                out_first <= (w_idx == '0);
                out_last  <= w_last;
            end
            // A bad length seen at the wrap keeps the old n_active but is flagged.
            if (w_wrap) begin
                cycle_count <= w_cc_inc;
                if (!w_cfg_ok) cfg_error <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        if (w_cfg_ok) begin
                            r_tgt       <= num_cycles;
                            cycle_count <= '0;
                            done        <= 1'b0;
                            cfg_error   <= 1'b0;
                            r_state     <= ST_ARM;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (!enable)
                        r_state <= ST_IDLE;
                    else if (w_sync_edge)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_wrap && (r_tgt != '0) && (w_cc_inc == r_tgt)) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!enable) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
